// File: rtl/store_byte_serializer_pkg.sv
// Shared MEM-stage definitions for the store byte serializer: store-type and
// FSM encodings plus small helpers for byte count and alignment checking.
package store_byte_serializer_pkg;

    typedef enum logic [1:0] {
        TIPO_SB  = 2'b00,
        TIPO_SH  = 2'b01,
        TIPO_RSV = 2'b10,
        TIPO_SW  = 2'b11
    } tipo_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERROR = 2'b11
    } state_e;

    // Number of memory beats a store of the given type needs.
    function automatic logic [2:0] byte_count(input tipo_e tipo);
        logic [2:0] n;
        case (tipo)
            TIPO_SB: n = 3'd1;
            TIPO_SH: n = 3'd2;
            TIPO_SW: n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    // Reserved type or a base address not aligned to the access size.
    function automatic logic req_bad(input tipo_e tipo, input logic [1:0] addr_lo);
        logic bad;
        case (tipo)
            TIPO_SB: bad = 1'b0;
            TIPO_SH: bad = addr_lo[0];
            TIPO_SW: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_byte_serializer_byte_select.sv
// Combinational byte picker: maps (store type, register value, beat index) to
// the big-endian byte for that beat and flags the final beat of the store.
module store_byte_select
    import store_byte_serializer_pkg::*;
(
    input  tipo_e       tipo_i,
    input  logic [31:0] dato_i,
    input  logic [1:0]  idx_i,
    output logic [7:0]  byte_o,
    output logic        last_o
);

    // Byte selection: most significant byte of the narrowed value goes first.
    always_comb begin
        byte_o = 8'h00;
        case (tipo_i)
            TIPO_SB: byte_o = dato_i[7:0];
            TIPO_SH: begin
                if (idx_i[0] == 1'b0) begin
                    byte_o = dato_i[15:8];
                end else begin
                    byte_o = dato_i[7:0];
                end
            end
            TIPO_SW: begin
                case (idx_i)
                    2'd0:    byte_o = dato_i[31:24];
                    2'd1:    byte_o = dato_i[23:16];
                    2'd2:    byte_o = dato_i[15:8];
                    2'd3:    byte_o = dato_i[7:0];
                    default: byte_o = 8'h00;
                endcase
            end
            default: byte_o = 8'h00;
        endcase
    end

    assign last_o = ({1'b0, idx_i} == (byte_count(tipo_i) - 3'd1));

endmodule

// File: rtl/store_byte_serializer.sv
// Serializes SB/SH/SW stores into big-endian byte beats on the byte-wide data
// memory port, stalling the MEM stage via o_ready until the store finishes.
module store_byte_serializer
    import store_byte_serializer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_tipo,
    input  logic [31:0]       i_dato,
    input  logic [ADDR_W-1:0] i_direccion,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_done,
    output logic              o_error
);

    state_e            state_q, state_d;
    tipo_e             tipo_q, tipo_d;
    logic [31:0]       dato_q, dato_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        byte_s;
    logic              last_s;

    store_byte_select u_sel (
        .tipo_i (tipo_q),
        .dato_i (dato_q),
        .idx_i  (idx_q),
        .byte_o (byte_s),
        .last_o (last_s)
    );

    // Next-state logic; addr_q tracks base+index so the beat address comes straight from a flop.
    always_comb begin
        state_d = state_q;
        tipo_d  = tipo_q;
        dato_d  = dato_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    tipo_d = tipo_e'(i_tipo);
                    dato_d = i_dato;
                    addr_d = i_direccion;
                    idx_d  = 2'd0;
                    if (req_bad(tipo_e'(i_tipo), i_direccion[1:0])) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (i_mem_ready) begin
                    if (last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            tipo_q  <= TIPO_SB;
            dato_q  <= 32'h0000_0000;
            addr_q  <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            tipo_q  <= tipo_d;
            dato_q  <= dato_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_mem_valid = (state_q == ST_WRITE);
    assign o_done      = (state_q == ST_DONE);
    assign o_error     = (state_q == ST_ERROR);
    assign o_mem_addr  = addr_q;
    assign o_mem_data  = byte_s;

endmodule

// File: tb/tb_store_byte_serializer.sv
// Directed bench for store_byte_serializer: expected beats go into a queue
// when a request is driven and are checked as the memory port presents them.
module tb_store_byte_serializer;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_tipo;
    logic [31:0] i_dato;
    logic [31:0] i_direccion;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_data;
    logic        o_done;
    logic        o_error;

    int n_cmp = 0;
    int n_bad = 0;
    logic [39:0] exp_q[$];

    store_byte_serializer #(.ADDR_W(32)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_tipo      (i_tipo),
        .i_dato      (i_dato),
        .i_direccion (i_direccion),
        .o_mem_valid (o_mem_valid),
        .i_mem_ready (i_mem_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] d, input int n, input int i);
        logic [31:0] sh;
        sh = d >> (8 * (n - 1 - i));
        return sh[7:0];
    endfunction

    // Memory-port monitor: every presented beat must match the queue head, popped on acceptance.
    always @(negedge i_clk) begin
        if (o_mem_valid) begin
            if (exp_q.size() == 0) begin
                chk("beat_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                chk("beat", {24'h0, o_mem_addr, o_mem_data}, {24'h0, exp_q[0]});
                if (i_mem_ready) void'(exp_q.pop_front());
            end
            chk("beat_excl", {62'h0, o_done, o_error}, 64'd0);
        end
    end

    task automatic do_req(input string tag, input logic [1:0] t, input logic [31:0] d,
                          input logic [31:0] a, input bit err, input int n,
                          input bit toggle, input int exp_cyc);
        int cyc;
        bit got;
        logic [1:0] flags;
        if (!err) begin
            for (int i = 0; i < n; i++) exp_q.push_back({a + 32'(i), exp_byte(d, n, i)});
        end
        i_tipo = t; i_dato = d; i_direccion = a; i_valid = 1'b1;
        i_mem_ready = toggle ? 1'b0 : 1'b1;
        @(negedge i_clk);
        chk({tag, "_ready_before"}, 64'(o_ready), 64'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_dato = $urandom;
        i_direccion = $urandom;
        cyc = 0; got = 1'b0; flags = 2'b00;
        while (!got && cyc < 60) begin
            @(negedge i_clk);
            cyc++;
            if (o_done || o_error) begin
                got = 1'b1;
                flags = {o_done, o_error};
            end else begin
                @(posedge i_clk); #1;
                if (toggle) i_mem_ready = ~i_mem_ready;
            end
        end
        chk({tag, "_completed"}, 64'(got), 64'd1);
        chk({tag, "_kind"}, 64'(flags), err ? 64'd1 : 64'd2);
        if (exp_cyc > 0) chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
        @(posedge i_clk); #1;
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        chk({tag, "_pulse_one_cycle"}, {62'h0, o_done, o_error}, 64'd0);
        chk({tag, "_ready_after"}, 64'(o_ready), 64'd1);
        chk({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        int dones;
        bit drop;
        bit seen_ready;
        i_reset_n = 1'b1; i_valid = 1'b0; i_tipo = 2'b00; i_dato = 32'h0;
        i_direccion = 32'h0; i_mem_ready = 1'b1;
        #2 i_reset_n = 1'b0;
        #2;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_mem_valid", 64'(o_mem_valid), 64'd0);
        chk("rst_addr", 64'(o_mem_addr), 64'd0);
        chk("rst_data", 64'(o_mem_data), 64'd0);
        chk("rst_done_err", {62'h0, o_done, o_error}, 64'd0);
        #19 i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        do_req("sw", 2'b11, 32'hA1B2C3D4, 32'h0000_0100, 1'b0, 4, 1'b0, 5);
        do_req("sh_stall", 2'b01, 32'hFFFF8765, 32'h0000_0202, 1'b0, 2, 1'b1, 0);
        do_req("sh", 2'b01, 32'h1234ABCD, 32'h0000_0010, 1'b0, 2, 1'b0, 3);

        // Back-to-back SB: second request held on i_valid until the first completes.
        exp_q.push_back({32'h7, 8'hEE});
        exp_q.push_back({32'h8, 8'h11});
        i_tipo = 2'b00; i_dato = 32'h000000EE; i_direccion = 32'h7; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_dato = 32'h00000011; i_direccion = 32'h8;
        @(negedge i_clk);
        chk("b2b_busy", 64'(o_ready), 64'd0);
        dones = 0; drop = 1'b0; seen_ready = 1'b0;
        for (int k = 0; k < 20 && dones < 2; k++) begin
            @(posedge i_clk); #1;
            if (drop) i_valid = 1'b0;
            @(negedge i_clk);
            if (o_done) dones++;
            if (o_ready && i_valid && !seen_ready) begin
                seen_ready = 1'b1;
                drop = 1'b1;
                chk("b2b_accept_after_done", 64'(dones), 64'd1);
            end
        end
        chk("b2b_dones", 64'(dones), 64'd2);
        chk("b2b_beats_left", 64'(exp_q.size()), 64'd0);
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;

        do_req("err_sw", 2'b11, 32'h11111111, 32'h0000_0101, 1'b1, 0, 1'b0, 1);
        do_req("err_sh", 2'b01, 32'h22222222, 32'h0000_0003, 1'b1, 0, 1'b0, 1);
        do_req("err_rsv", 2'b10, 32'h33333333, 32'h0000_0000, 1'b1, 0, 1'b0, 1);
        do_req("wrap", 2'b11, 32'h01020304, 32'hFFFF_FFFC, 1'b0, 4, 1'b0, 5);

        // Reset in the middle of a word store, after two beats have been accepted.
        for (int i = 0; i < 4; i++) exp_q.push_back({32'h40 + 32'(i), exp_byte(32'hCAFEBABE, 4, i)});
        i_tipo = 2'b11; i_dato = 32'hCAFEBABE; i_direccion = 32'h40; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        @(posedge i_clk); #1;
        i_reset_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(o_ready), 64'd1);
        chk("midrst_mem_valid", 64'(o_mem_valid), 64'd0);
        chk("midrst_addr_data", {24'h0, o_mem_addr, o_mem_data}, 64'd0);
        chk("midrst_done_err", {62'h0, o_done, o_error}, 64'd0);
        chk("midrst_beats_left", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        @(negedge i_clk);
        chk("midrst_no_done", 64'(o_done), 64'd0);
        #2 i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        do_req("post_rst_sb", 2'b00, 32'h5A5A5A77, 32'h0000_0033, 1'b0, 1, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_byte_serializer.md
Name: store_byte_serializer

Overview:
- Store-side inverse of the 16→32 sign extension on the load path: narrows a 32-bit register value to byte, halfword or word according to store type (SB/SH/SW).
- Writes the result to the byte-wide data memory one byte per accepted memory beat, big-endian.
- Sits between the MEM pipeline stage and the data memory port.
- Holds the pipeline through o_ready until the store completes.

Parameters:
- ADDR_W, 32, width of byte address on both sides.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  store request valid.
- o_ready  out  1  unit can accept a request (high only in IDLE).
- i_tipo  in  2  store type: 00=SB, 01=SH, 11=SW, 10=reserved.
- i_dato  in  32  register value to store.
- i_direccion  in  ADDR_W  base byte address.
- o_mem_valid  out  1  byte write beat valid.
- i_mem_ready  in  1  memory accepts current beat.
- o_mem_addr  out  ADDR_W  byte address of current beat.
- o_mem_data  out  8  byte of current beat.
- o_done  out  1  one-cycle pulse: store completed.
- o_error  out  1  one-cycle pulse: request rejected (misaligned or reserved type).

Behaviour:
- Reset (async, i_reset_n=0): state IDLE, o_ready=1, o_mem_valid=0, o_mem_addr=0, o_mem_data=0, o_done=0, o_error=0, byte index=0, latched registers=0.
- States:
  - IDLE: o_ready=1. On i_valid&o_ready, latch i_dato, i_direccion, i_tipo and check the request.
    - Reserved type, or SH with addr[0]=1, or SW with addr[1:0]≠00 → ERROR.
    - Otherwise → WRITE, index=0.
  - WRITE: o_mem_valid=1, o_ready=0. o_mem_addr=base+index (modulo 2^ADDR_W). o_mem_data selected by type and index:
    - SB: index0=d[7:0].
    - SH: index0=d[15:8], index1=d[7:0].
    - SW: index0=d[31:24], index1=d[23:16], index2=d[15:8], index3=d[7:0].
  - WRITE beat handshake: a beat completes on a cycle with o_mem_valid&i_mem_ready. On completion, if index=last (0/1/3 for SB/SH/SW) → DONE; else index+1 and stay in WRITE.
  - DONE: o_done=1 for exactly one cycle, o_mem_valid=0, o_ready=0 → IDLE.
  - ERROR: o_error=1 for exactly one cycle, no memory beat issued, o_ready=0 → IDLE.
- o_mem_addr and o_mem_data are held stable while o_mem_valid=1 and i_mem_ready=0. Stalls are unbounded.
- Latency with i_mem_ready held at 1: accept→o_done = 1+N+1 cycles (N = 1/2/4 bytes). Next request is accepted the cycle after DONE.
- Inputs are ignored outside IDLE. Changes to i_dato or i_direccion mid-store have no effect.
- i_valid with o_ready=0 is not accepted. The requester holds the request until o_ready.
- Address wrap: base 0xFFFFFFFC with SW writes FC, FD, FE, FF. For SW/SH, aligned base never wraps mid-store.
- Reset asserted mid-store: immediate IDLE with all outputs at reset values. No o_done, and the partial write is not rolled back.
- o_mem_valid and o_done/o_error are never high in the same cycle.

Decomposition:
- Shared package (MEM stage): store-type encodings TIPO_SB/SH/SW/RSV, FSM state encodings, byte count per type.
- One natural sub-module, store_byte_select: combinational (tipo, dato, index) → byte and last-index flag. FSM, counter and address adder stay in the top.

Test Plan:
- SW d=0xA1B2C3D4 @0x100, ready=1 → beats (0x100,A1)(0x101,B2)(0x102,C3)(0x103,D4). o_done pulses on cycle 6 after accept.
- SH d=0xFFFF8765 @0x202, ready toggling 1/0 → beats (0x202,87)(0x203,65). Addr/data stable during ready=0. One o_done.
- SB d=0x000000EE @0x7, then immediate SB d=0x11 @0x8 → two single beats (0x7,EE)(0x8,11). Second request accepted only after DONE.
- Misaligned SW @0x101, SH @0x3, reserved tipo 10 @0x0 → o_error one cycle each, zero memory beats, o_ready back high next cycle.
- SW @0xFFFFFFFC d=0x01020304 → addresses FC..FF, data 01..04, no X or overflow.
- SW in progress, i_reset_n low after second beat → outputs at reset values asynchronously. After release, fresh SB completes normally.
